// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: MIPS opcode/funct
// fields, Tuse/Tnew timing codes, forward-select codes and decode helpers.
package hazard_ctrl_pkg;

  localparam logic [5:0] OpSpecial = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04,
                         OpBne = 6'h05, OpBlez = 6'h06, OpBgtz = 6'h07, OpAddi = 6'h08,
                         OpAddiu = 6'h09, OpSlti = 6'h0a, OpSltiu = 6'h0b, OpAndi = 6'h0c,
                         OpOri = 6'h0d, OpXori = 6'h0e, OpLui = 6'h0f, OpLb = 6'h20,
                         OpLh = 6'h21, OpLw = 6'h23, OpLbu = 6'h24, OpLhu = 6'h25,
                         OpSb = 6'h28, OpSh = 6'h29, OpSw = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnSllv = 6'h04,
                         FnSrlv = 6'h06, FnSrav = 6'h07, FnJr = 6'h08, FnJalr = 6'h09,
                         FnMfhi = 6'h10, FnMthi = 6'h11, FnMflo = 6'h12, FnMtlo = 6'h13,
                         FnMult = 6'h18, FnMultu = 6'h19, FnDiv = 6'h1a, FnDivu = 6'h1b,
                         FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23,
                         FnAnd = 6'h24, FnOr = 6'h25, FnXor = 6'h26, FnNor = 6'h27,
                         FnSlt = 6'h2a, FnSltu = 6'h2b;

  // Cycles until a source operand is consumed, counted from D
  localparam logic [1:0] TuseNow = 2'd0, TuseAlu = 2'd1, TuseStore = 2'd2, TuseNone = 2'd3;
  // Cycles until a result becomes forwardable
  localparam logic [1:0] Tnew0 = 2'd0, Tnew1 = 2'd1, Tnew2 = 2'd2;

  localparam logic [2:0] FwdDRf = 3'd0, FwdDRfwd = 3'd1, FwdDAoM = 3'd2, FwdDPc8M = 3'd3,
                         FwdDPc8E = 3'd4;
  localparam logic [1:0] FwdEPipe = 2'd0, FwdERfwd = 2'd1, FwdEAoM = 2'd2, FwdEPc8M = 2'd3;

  localparam logic StIdle = 1'b0, StBusy = 1'b1;

  localparam int unsigned StageD = 0, StageE = 1, StageM = 2, StageW = 3;

  typedef struct packed {
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew;
    logic       load;
    logic       store;
    logic       link;    // jal/jalr: result is PC+8
    logic       md_op;   // mult/multu/div/divu
    logic       md_div;  // div/divu
    logic       md_any;  // any instruction touching the md unit or hi/lo
  } hz_dec_t;

  function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                     input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return (src != 5'd0) &&
           (((src == a3_e) && (tnew_e > tuse)) || ((src == a3_m) && (tnew_m > tuse)));
  endfunction

  // Youngest matching stage wins; a match whose value is not yet ready
  // blocks older stages so a stale value is never selected.
  function automatic logic [2:0] fwd_sel_d(input logic [4:0] src, input logic [4:0] a3_e,
                                           input logic link_e, input logic [4:0] a3_m,
                                           input logic [1:0] tnew_m, input logic link_m,
                                           input logic [4:0] a3_w);
    logic [2:0] sel;
    sel = FwdDRf;
    if (src != 5'd0) begin
      if (src == a3_e) sel = link_e ? FwdDPc8E : FwdDRf;
      else if (src == a3_m) sel = (tnew_m == Tnew0) ? (link_m ? FwdDPc8M : FwdDAoM) : FwdDRf;
      else if (src == a3_w) sel = FwdDRfwd;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src, input logic [4:0] a3_m,
                                           input logic [1:0] tnew_m, input logic link_m,
                                           input logic [4:0] a3_w);
    logic [1:0] sel;
    sel = FwdEPipe;
    if (src != 5'd0) begin
      if (src == a3_m) sel = (tnew_m == Tnew0) ? (link_m ? FwdEPc8M : FwdEAoM) : FwdEPipe;
      else if (src == a3_w) sel = FwdERfwd;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_decode.sv
// Per-stage instruction classifier: operand use times, result ready time
// (aged to the stage this instance sits in) and class flags.
module hz_decode import hazard_ctrl_pkg::*; #(
  parameter int unsigned Stage = StageE
) (
  input  logic [31:0] i_ir,
  output hz_dec_t     o_dec
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused_ir;

  assign w_op        = i_ir[31:26];
  assign w_fn        = i_ir[5:0];
  assign w_unused_ir = ^i_ir[25:6];

  // Classify the instruction; unknown encodings use nothing and write nothing
  always_comb begin
    o_dec         = '0;
    o_dec.tuse_rs = TuseNone;
    o_dec.tuse_rt = TuseNone;
    case (w_op)
      OpSpecial: begin
        case (w_fn)
          FnSll, FnSrl, FnSra: begin
            o_dec.tuse_rt = TuseAlu;
            o_dec.tnew    = Tnew1;
          end
          FnSllv, FnSrlv, FnSrav, FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
          FnSlt, FnSltu: begin
            o_dec.tuse_rs = TuseAlu;
            o_dec.tuse_rt = TuseAlu;
            o_dec.tnew    = Tnew1;
          end
          FnJr: o_dec.tuse_rs = TuseNow;
          FnJalr: begin
            o_dec.tuse_rs = TuseNow;
            o_dec.link    = 1'b1;
          end
          FnMfhi, FnMflo: begin
            o_dec.tnew   = Tnew1;
            o_dec.md_any = 1'b1;
          end
          FnMthi, FnMtlo: begin
            o_dec.tuse_rs = TuseAlu;
            o_dec.md_any  = 1'b1;
          end
          FnMult, FnMultu, FnDiv, FnDivu: begin
            o_dec.tuse_rs = TuseAlu;
            o_dec.tuse_rt = TuseAlu;
            o_dec.md_op   = 1'b1;
            o_dec.md_div  = w_fn[1];
            o_dec.md_any  = 1'b1;
          end
          default: ;
        endcase
      end
      OpBeq, OpBne: begin
        o_dec.tuse_rs = TuseNow;
        o_dec.tuse_rt = TuseNow;
      end
      OpBlez, OpBgtz: o_dec.tuse_rs = TuseNow;
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: begin
        o_dec.tuse_rs = TuseAlu;
        o_dec.tnew    = Tnew1;
      end
      OpLui: o_dec.tnew = Tnew1;
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        o_dec.tuse_rs = TuseAlu;
        o_dec.tnew    = Tnew2;
        o_dec.load    = 1'b1;
      end
      OpSb, OpSh, OpSw: begin
        o_dec.tuse_rs = TuseAlu;
        o_dec.tuse_rt = TuseStore;
        o_dec.store   = 1'b1;
      end
      OpJal: o_dec.link = 1'b1;
      OpJ: ;
      default: ;
    endcase
    if (Stage == StageM) o_dec.tnew = o_dec.load ? Tnew1 : Tnew0;
    else if (Stage == StageW) o_dec.tnew = Tnew0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/md stall generation, forwarding selects
// for D, E and M, multiply/divide busy sequencer and a stalled-cycle counter.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  input  logic [31:0] IR_W,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [4:0]  A3_W,
  output logic        Stall,
  output logic [2:0]  ForwardRSD,
  output logic [2:0]  ForwardRTD,
  output logic [1:0]  ForwardRSE,
  output logic [1:0]  ForwardRTE,
  output logic        ForwardRTM,
  output logic        StartE,
  output logic        MdBusy,
  output logic [31:0] StallCnt
);

  localparam int unsigned CntMax = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  hz_dec_t w_dec_d, w_dec_e, w_dec_m, w_dec_w;
  logic    w_unused_dec;
  logic    w_stall_data, w_stall_md;

  logic            r_state_q, r_state_d;
  logic [CntW-1:0] r_cnt_q, r_cnt_d;
  logic [31:0]     r_stall_cnt_q, r_stall_cnt_d;

  hz_decode #(.Stage(StageD)) u_dec_d (.i_ir(IR_D), .o_dec(w_dec_d));
  hz_decode #(.Stage(StageE)) u_dec_e (.i_ir(IR_E), .o_dec(w_dec_e));
  hz_decode #(.Stage(StageM)) u_dec_m (.i_ir(IR_M), .o_dec(w_dec_m));
  hz_decode #(.Stage(StageW)) u_dec_w (.i_ir(IR_W), .o_dec(w_dec_w));

  // W results are always in the register file or RFWD, so W decode is informational
  assign w_unused_dec = ^{w_dec_d, w_dec_e, w_dec_m, w_dec_w};

  assign w_stall_data =
      src_stall(IR_D[25:21], w_dec_d.tuse_rs, A3_E, w_dec_e.tnew, A3_M, w_dec_m.tnew) |
      src_stall(IR_D[20:16], w_dec_d.tuse_rt, A3_E, w_dec_e.tnew, A3_M, w_dec_m.tnew);
  assign w_stall_md   = w_dec_d.md_any & (StartE | MdBusy);
  assign Stall        = w_stall_data | w_stall_md;

  assign ForwardRSD = fwd_sel_d(IR_D[25:21], A3_E, w_dec_e.link, A3_M, w_dec_m.tnew,
                                w_dec_m.link, A3_W);
  assign ForwardRTD = fwd_sel_d(IR_D[20:16], A3_E, w_dec_e.link, A3_M, w_dec_m.tnew,
                                w_dec_m.link, A3_W);
  assign ForwardRSE = fwd_sel_e(IR_E[25:21], A3_M, w_dec_m.tnew, w_dec_m.link, A3_W);
  assign ForwardRTE = fwd_sel_e(IR_E[20:16], A3_M, w_dec_m.tnew, w_dec_m.link, A3_W);
  assign ForwardRTM = w_dec_m.store & (IR_M[20:16] != 5'd0) & (IR_M[20:16] == A3_W);

  assign MdBusy   = (r_state_q == StBusy);
  assign StallCnt = r_stall_cnt_q;

  // MD sequencer: launch from idle, count down busy cycles, ignore new ops while busy
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    StartE    = 1'b0;
    case (r_state_q)
      StIdle: begin
        if (w_dec_e.md_op && !reset) begin
          StartE    = 1'b1;
          r_state_d = StBusy;
          r_cnt_d   = w_dec_e.md_div ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
        end
      end
      StBusy: begin
        if (r_cnt_q <= CntW'(1)) begin
          r_state_d = StIdle;
          r_cnt_d   = '0;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  // Saturating count of stalled cycles
  always_comb begin
    r_stall_cnt_d = r_stall_cnt_q;
    if (Stall && (r_stall_cnt_q != 32'hFFFF_FFFF)) r_stall_cnt_d = r_stall_cnt_q + 32'd1;
  end

  // State registers; reset aborts any in-flight md sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q     <= StIdle;
      r_cnt_q       <= '0;
      r_stall_cnt_q <= '0;
    end else begin
      r_state_q     <= r_state_d;
      r_cnt_q       <= r_cnt_d;
      r_stall_cnt_q <= r_stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: drives pipeline snapshots on the falling
// edge and checks combinational selects and sequencer state shortly after.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M, IR_W;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        Stall, ForwardRTM, StartE, MdBusy;
  logic [2:0]  ForwardRSD, ForwardRTD;
  logic [1:0]  ForwardRSE, ForwardRTE;
  logic [31:0] StallCnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .Stall(Stall), .ForwardRSD(ForwardRSD),
    .ForwardRTD(ForwardRTD), .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE),
    .ForwardRTM(ForwardRTM), .StartE(StartE), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic [31:0] w, input logic [4:0] a3e, input logic [4:0] a3m,
                       input logic [4:0] a3w);
    @(negedge clk);
    IR_D = d; IR_E = e; IR_M = m; IR_W = w;
    A3_E = a3e; A3_M = a3m; A3_W = a3w;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    IR_D = '0; IR_E = '0; IR_M = '0; IR_W = '0; A3_E = '0; A3_M = '0; A3_W = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IR_D = rtype(0, 0, 3, 6'h12); IR_E = rtype(1, 2, 0, 6'h1a);
    IR_M = '0; IR_W = '0; A3_E = '0; A3_M = '0; A3_W = '0;
    @(negedge clk); #1;
    checks++; if (StartE !== 1'b0) begin failures++; $display("FAIL rst_start: got %0b want 0", StartE); end
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", MdBusy); end
    checks++; if (StallCnt !== 32'd0) begin failures++; $display("FAIL rst_cnt: got %0h want 0", StallCnt); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %0b want 0", Stall); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (StartE !== 1'b1) begin failures++; $display("FAIL rst_rel_start: got %0b want 1", StartE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(rtype(8, 1, 9, 6'h21), itype(6'h23, 1, 8, 0), 0, 0, 8, 0, 0);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %0b want 1", Stall); end
    drive(rtype(8, 1, 9, 6'h21), 0, itype(6'h23, 1, 8, 0), 0, 0, 8, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_release: got %0b want 0", Stall); end
    drive(0, rtype(8, 1, 9, 6'h21), 0, itype(6'h23, 1, 8, 0), 0, 0, 8);
    checks++; if (ForwardRSE !== 2'd1) begin failures++; $display("FAIL lu_rse: got %0d want 1", ForwardRSE); end
    checks++; if (ForwardRTE !== 2'd0) begin failures++; $display("FAIL lu_rte: got %0d want 0", ForwardRTE); end
    checks++; if (StallCnt !== 32'd1) begin failures++; $display("FAIL lu_cnt: got %0d want 1", StallCnt); end
  endtask

  task automatic test_fwd_d();
    apply_reset();
    drive(itype(6'h04, 5, 0, 4), 0, rtype(1, 2, 5, 6'h21), 0, 0, 5, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL br_m_stall: got %0b want 0", Stall); end
    checks++; if (ForwardRSD !== 3'd2) begin failures++; $display("FAIL br_m_rsd: got %0d want 2", ForwardRSD); end
    checks++; if (ForwardRTD !== 3'd0) begin failures++; $display("FAIL br_m_rtd: got %0d want 0", ForwardRTD); end
    drive(itype(6'h04, 5, 6, 4), rtype(1, 2, 5, 6'h21), 0, 0, 5, 0, 0);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL br_e_stall: got %0b want 1", Stall); end
    drive(itype(6'h04, 5, 6, 4), 0, itype(6'h23, 1, 6, 0), 0, 0, 6, 5);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL br_ld_stall: got %0b want 1", Stall); end
    checks++; if (ForwardRSD !== 3'd1) begin failures++; $display("FAIL br_w_rsd: got %0d want 1", ForwardRSD); end
    drive(rtype(31, 0, 0, 6'h08), {6'h03, 26'h10}, 0, 0, 31, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL jr_e_stall: got %0b want 0", Stall); end
    checks++; if (ForwardRSD !== 3'd4) begin failures++; $display("FAIL jr_e_rsd: got %0d want 4", ForwardRSD); end
    drive(rtype(31, 0, 0, 6'h08), 0, {6'h03, 26'h10}, 0, 0, 31, 0);
    checks++; if (ForwardRSD !== 3'd3) begin failures++; $display("FAIL jr_m_rsd: got %0d want 3", ForwardRSD); end
    drive(rtype(31, 0, 0, 6'h08), {6'h03, 26'h10}, rtype(1, 2, 31, 6'h21), 0, 31, 31, 31);
    checks++; if (ForwardRSD !== 3'd4) begin failures++; $display("FAIL prio_e_rsd: got %0d want 4", ForwardRSD); end
    drive(rtype(31, 0, 0, 6'h08), 0, rtype(1, 2, 31, 6'h21), 0, 0, 31, 31);
    checks++; if (ForwardRSD !== 3'd2) begin failures++; $display("FAIL prio_m_rsd: got %0d want 2", ForwardRSD); end
  endtask

  task automatic test_fwd_e_m();
    apply_reset();
    drive(0, rtype(4, 4, 3, 6'h21), rtype(1, 2, 4, 6'h21), 0, 0, 4, 0);
    checks++; if (ForwardRSE !== 2'd2) begin failures++; $display("FAIL e_m_rse: got %0d want 2", ForwardRSE); end
    checks++; if (ForwardRTE !== 2'd2) begin failures++; $display("FAIL e_m_rte: got %0d want 2", ForwardRTE); end
    drive(0, rtype(31, 4, 3, 6'h21), {6'h03, 26'h10}, 0, 0, 31, 4);
    checks++; if (ForwardRSE !== 2'd3) begin failures++; $display("FAIL e_jal_rse: got %0d want 3", ForwardRSE); end
    checks++; if (ForwardRTE !== 2'd1) begin failures++; $display("FAIL e_w_rte: got %0d want 1", ForwardRTE); end
    drive(0, 0, itype(6'h2b, 1, 7, 0), 0, 0, 0, 7);
    checks++; if (ForwardRTM !== 1'b1) begin failures++; $display("FAIL rtm_hit: got %0b want 1", ForwardRTM); end
    drive(0, 0, itype(6'h2b, 1, 7, 0), 0, 0, 0, 6);
    checks++; if (ForwardRTM !== 1'b0) begin failures++; $display("FAIL rtm_miss: got %0b want 0", ForwardRTM); end
    drive(0, 0, itype(6'h23, 1, 7, 0), 0, 0, 7, 7);
    checks++; if (ForwardRTM !== 1'b0) begin failures++; $display("FAIL rtm_load: got %0b want 0", ForwardRTM); end
    drive(itype(6'h2b, 2, 7, 0), itype(6'h23, 1, 7, 0), 0, 0, 7, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL sw_data_stall: got %0b want 0", Stall); end
    drive(itype(6'h2b, 7, 2, 0), itype(6'h23, 1, 7, 0), 0, 0, 7, 0, 0);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL sw_base_stall: got %0b want 1", Stall); end
  endtask

  task automatic test_zero_unknown();
    apply_reset();
    drive(rtype(0, 0, 3, 6'h21), itype(6'h23, 1, 0, 0), 0, 0, 0, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL z_stall: got %0b want 0", Stall); end
    checks++; if ({ForwardRSD, ForwardRTD} !== 6'd0) begin failures++; $display("FAIL z_fwd_d: got %0h want 0", {ForwardRSD, ForwardRTD}); end
    drive(rtype(0, 0, 0, 6'h08), {6'h03, 26'h10}, rtype(1, 2, 0, 6'h21), 0, 0, 0, 0);
    checks++; if (ForwardRSD !== 3'd0) begin failures++; $display("FAIL z_jr_rsd: got %0d want 0", ForwardRSD); end
    checks++; if ({ForwardRSE, ForwardRTE} !== 4'd0) begin failures++; $display("FAIL z_fwd_e: got %0h want 0", {ForwardRSE, ForwardRTE}); end
    drive(0, 0, itype(6'h2b, 1, 0, 0), 0, 0, 0, 0);
    checks++; if (ForwardRTM !== 1'b0) begin failures++; $display("FAIL z_rtm: got %0b want 0", ForwardRTM); end
    drive(itype(6'h3f, 8, 8, 0), itype(6'h23, 1, 8, 0), 0, 0, 8, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL unk_d_stall: got %0b want 0", Stall); end
    drive(itype(6'h04, 8, 0, 4), itype(6'h3f, 1, 8, 0), 0, 0, 8, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL unk_e_stall: got %0b want 0", Stall); end
  endtask

  task automatic test_md_seq();
    logic exp_s;
    apply_reset();
    drive(rtype(0, 0, 3, 6'h12), rtype(1, 2, 0, 6'h1a), 0, 0, 0, 0, 0);
    checks++; if (StartE !== 1'b1) begin failures++; $display("FAIL div_start: got %0b want 1", StartE); end
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL div_stall0: got %0b want 1", Stall); end
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL div_busy0: got %0b want 0", MdBusy); end
    for (int i = 1; i <= 10; i++) begin
      drive(rtype(0, 0, 3, 6'h12), 0, (i == 1) ? rtype(1, 2, 0, 6'h1a) : 32'h0, 0, 0, 0, 0);
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL div_stall[%0d]: got %0b want 1", i, Stall); end
      checks++; if (MdBusy !== 1'b1) begin failures++; $display("FAIL div_busy[%0d]: got %0b want 1", i, MdBusy); end
      checks++; if (StartE !== 1'b0) begin failures++; $display("FAIL div_nostart[%0d]: got %0b want 0", i, StartE); end
    end
    drive(rtype(0, 0, 3, 6'h12), 0, 0, 0, 0, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL div_done_stall: got %0b want 0", Stall); end
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL div_done_busy: got %0b want 0", MdBusy); end
    checks++; if (StallCnt !== 32'd11) begin failures++; $display("FAIL div_cnt: got %0d want 11", StallCnt); end
    drive(0, rtype(1, 2, 0, 6'h18), 0, 0, 0, 0, 0);
    checks++; if (StartE !== 1'b1) begin failures++; $display("FAIL mult_start: got %0b want 1", StartE); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mult_stall0: got %0b want 0", Stall); end
    for (int i = 1; i <= 5; i++) begin
      exp_s = (i == 1);
      drive((i == 1) ? rtype(1, 0, 0, 6'h11) : rtype(1, 2, 3, 6'h21), 0, 0, 0, 0, 0, 0);
      checks++; if (MdBusy !== 1'b1) begin failures++; $display("FAIL mult_busy[%0d]: got %0b want 1", i, MdBusy); end
      checks++; if (Stall !== exp_s) begin failures++; $display("FAIL mult_stall[%0d]: got %0b want %0b", i, Stall, exp_s); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL mult_done: got %0b want 0", MdBusy); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(rtype(0, 0, 3, 6'h12), rtype(1, 2, 0, 6'h1a), 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) drive(rtype(0, 0, 3, 6'h12), 0, 0, 0, 0, 0, 0);
    checks++; if (MdBusy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %0b want 1", MdBusy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %0b want 0", MdBusy); end
    checks++; if (StallCnt !== 32'd0) begin failures++; $display("FAIL mid_rst_cnt: got %0d want 0", StallCnt); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall: got %0b want 0", Stall); end
    @(negedge clk); reset = 1'b0;
    drive(rtype(0, 0, 3, 6'h12), 0, 0, 0, 0, 0, 0);
    checks++; if (MdBusy !== 1'b0) begin failures++; $display("FAIL mid_post_busy: got %0b want 0", MdBusy); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mid_post_stall: got %0b want 0", Stall); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_load_use();
    test_fwd_d();
    test_fwd_e_m();
    test_zero_unknown();
    test_md_seq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
